fll_cfg_responder: RTL

//  Responder (FLL side) of the FLL_BUS config handshake (req/ack/addr/web/wdata/rdata).

---
 rtl/fll_cfg_pkg.sv | 35 +++
 rtl/fll_lock_model.sv | 64 ++++++
 rtl/fll_cfg_responder.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fll_cfg_pkg.sv
`default_nettype none
// ============================================================================
// fll_cfg_pkg : register map, field positions and FSM encodings shared by the
//               FLL config responder and its lock model.
// Rev 1.0
// ============================================================================
package fll_cfg_pkg;

  typedef enum logic [1:0] {
    REG_STATUS = 2'd0,
    REG_CFG1   = 2'd1,
    REG_CFG2   = 2'd2,
    REG_INTEG  = 2'd3
  } reg_idx_e;

  localparam int CFG1_MODE_BIT = 31;

  localparam int MFI_LSB = 0;
  localparam int MFI_MSB = 15;
  localparam int MFI_W   = 16;
  localparam int DCO_LSB = 16;
  localparam int DCO_MSB = 25;
  localparam int DCO_W   = 10;

  localparam logic [31:0] CFG1_RST  = 32'h0000_0000;
  localparam logic [31:0] CFG2_RST  = 32'h0000_0000;
  localparam logic [31:0] INTEG_RST = 32'h0000_0000;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/fll_lock_model.sv
`default_nettype none
// ============================================================================
// fll_lock_model : behavioural lock timer for one FLL; lock follows a
//                  closed-loop reconfiguration after LOCK_CYCLES+1 cycles.
// Rev 1.0
// ============================================================================
module fll_lock_model
  import fll_cfg_pkg::*;
#(
  parameter int LOCK_CYCLES = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic reconf_i,
  input  logic closed_loop_i,
  output logic lock_o
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             lock_q, lock_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    lock_d = lock_q;
    if (reconf_i) begin
      // Any reconfiguration restarts from scratch; open loop simply parks it.
      lock_d = 1'b0;
      if (closed_loop_i) begin
        cnt_d  = CNT_W'(LOCK_CYCLES);
        busy_d = 1'b1;
      end else begin
        cnt_d  = '0;
        busy_d = 1'b0;
      end
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        lock_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
      lock_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      lock_q <= lock_d;
    end
  end

  assign lock_o = lock_q;

endmodule
`default_nettype wire

// File: rtl/fll_cfg_responder.sv
`default_nettype none
// ============================================================================
// fll_cfg_responder : FLL_BUS config target with per-FLL CFG1/CFG2/INTEG banks,
//                     a read-only STATUS register and a behavioural lock model.
// Rev 1.0
// ============================================================================
module fll_cfg_responder
  import fll_cfg_pkg::*;
#(
  parameter int NR_FLLS     = 3,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int ACK_LAT     = 2,
  parameter int LOCK_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic                  web_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic                  ack_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic [NR_FLLS-1:0]    lock_o,
  output logic [NR_FLLS*16-1:0] mfi_o,
  output logic [NR_FLLS*10-1:0] dco_o
);

  localparam int FIDX_W = ADDR_W - 2;
  localparam int LAT_W  = (ACK_LAT > 1) ? $clog2(ACK_LAT) : 1;

  logic [1:0]        state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              web_q, web_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic [DATA_W-1:0] cfg1_q  [NR_FLLS];
  logic [DATA_W-1:0] cfg2_q  [NR_FLLS];
  logic [DATA_W-1:0] integ_q [NR_FLLS];

  logic              w_commit;
  logic [FIDX_W-1:0] w_fidx;
  reg_idx_e          w_reg;
  logic [DATA_W-1:0] w_rd_mux;
  logic [NR_FLLS-1:0] w_lock;
  logic [NR_FLLS-1:0] w_reconf;
  logic [NR_FLLS-1:0] w_closed;

  assign w_fidx = addr_q[ADDR_W-1:2];
  assign w_reg  = reg_idx_e'(addr_q[1:0]);

  // Handshake FSM: only the values latched in IDLE are used for the access.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    addr_d   = addr_q;
    web_d    = web_q;
    wdata_d  = wdata_q;
    ack_d    = 1'b0;
    rdata_d  = '0;
    w_commit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          addr_d  = addr_i;
          web_d   = web_i;
          wdata_d = wdata_i;
          lat_d   = LAT_W'(ACK_LAT - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          w_commit = 1'b1;
          ack_d    = 1'b1;
          rdata_d  = web_q ? w_rd_mux : '0;
          state_d  = ST_ACK;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      ST_ACK: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (!req_i) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      web_q   <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      web_q   <= web_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Out-of-range FLL indices match no bank, so writes drop and reads return 0.
  always_comb begin
    w_rd_mux = '0;
    for (int i = 0; i < NR_FLLS; i++) begin
      if (w_fidx == FIDX_W'(i)) begin
        case (w_reg)
          REG_STATUS: begin
            w_rd_mux[DATA_W-1] = w_lock[i];
            if (w_lock[i]) w_rd_mux[MFI_MSB:MFI_LSB] = integ_q[i][MFI_MSB:MFI_LSB];
          end
          REG_CFG1:  w_rd_mux = cfg1_q[i];
          REG_CFG2:  w_rd_mux = cfg2_q[i];
          REG_INTEG: w_rd_mux = integ_q[i];
          default:   w_rd_mux = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_FLLS; i++) begin
        cfg1_q[i]  <= DATA_W'(CFG1_RST);
        cfg2_q[i]  <= DATA_W'(CFG2_RST);
        integ_q[i] <= DATA_W'(INTEG_RST);
      end
    end else if (w_commit && !web_q) begin
      for (int i = 0; i < NR_FLLS; i++) begin
        if (w_fidx == FIDX_W'(i)) begin
          case (w_reg)
            REG_CFG1:  cfg1_q[i]  <= wdata_q;
            REG_CFG2:  cfg2_q[i]  <= wdata_q;
            REG_INTEG: integ_q[i] <= wdata_q;
            default:   ;
          endcase
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NR_FLLS; i++) begin : g_fll
      // Loop mode is judged on CFG1 as it will be after this write.
      assign w_reconf[i] = w_commit && !web_q && (w_fidx == FIDX_W'(i)) &&
                           ((w_reg == REG_CFG1) || (w_reg == REG_INTEG));
      assign w_closed[i] = (w_reg == REG_CFG1) ? wdata_q[CFG1_MODE_BIT]
                                               : cfg1_q[i][CFG1_MODE_BIT];

      fll_lock_model #(
        .LOCK_CYCLES (LOCK_CYCLES)
      ) u_lock (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .reconf_i      (w_reconf[i]),
        .closed_loop_i (w_closed[i]),
        .lock_o        (w_lock[i])
      );

      assign mfi_o[i*MFI_W +: MFI_W] = integ_q[i][MFI_MSB:MFI_LSB];
      assign dco_o[i*DCO_W +: DCO_W] = integ_q[i][DCO_MSB:DCO_LSB];
    end
  endgenerate

  assign ack_o   = ack_q;
  assign rdata_o = rdata_q;
  assign lock_o  = w_lock;

endmodule
`default_nettype wire
